// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// The master side issues load/store requests; the slave side returns data or a store ack.
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked RV32I data-memory responder with fixed wait-state latency and byte-lane handling.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned/illegal accesses on rsp_err.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic           clk,
    input logic           rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned Words = 2 ** (ADDR_W - 2);
    localparam int unsigned CntW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CntW-1:0] CntLast = (WAIT_STATES > 0) ? CntW'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [Words];

    logic              accept, enter_resp, fault;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [2:0]        op_f3;
    logic [31:0]       op_wdata;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic              is_byte, is_half, uns;
    logic [31:0]       rd_word, load_val, merged, wsh, rdata_d;
    logic [3:0]        be;

    assign accept = bus.req_valid && (state_q == StIdle);

    // With zero wait states RESP is entered on the accept edge, so decode straight from the bus.
    assign op_we    = (state_q == StIdle) ? bus.req_we     : we_q;
    assign op_addr  = (state_q == StIdle) ? bus.req_addr   : addr_q;
    assign op_f3    = (state_q == StIdle) ? bus.req_funct3 : funct3_q;
    assign op_wdata = (state_q == StIdle) ? bus.req_wdata  : wdata_q;

    always_comb begin
        is_byte  = (op_f3[1:0] == 2'b00);
        is_half  = (op_f3[1:0] == 2'b01);
        uns      = op_f3[2];
        word_idx = op_addr[ADDR_W-1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        lane  = op_addr[1:0];
        fault = (op_f3 == 3'b011) || (op_f3[2:1] == 2'b11) ||
                (is_half && op_addr[0]) ||
                (!is_byte && !is_half && (op_addr[1:0] != 2'b00));
`else
        lane  = is_byte ? op_addr[1:0] : (is_half ? {op_addr[1], 1'b0} : 2'b00);
        fault = 1'b0;
`endif
        rd_word = mem[word_idx];
        if (is_byte) begin
            load_val = {{24{!uns && rd_word[{lane, 3'b000} + 7]}}, rd_word[{lane, 3'b000} +: 8]};
        end else if (is_half) begin
            load_val = {{16{!uns && rd_word[{lane[1], 4'b1111}]}},
                        rd_word[{lane[1], 4'b0000} +: 16]};
        end else begin
            load_val = rd_word;
        end
        be  = is_byte ? (4'b0001 << lane) : (is_half ? (4'b0011 << lane) : 4'b1111);
        wsh = op_wdata << {lane, 3'b000};
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wsh[8*b +: 8] : rd_word[8*b +: 8];
        end
        rdata_d = (fault || op_we) ? 32'h0 : load_val;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = '0;
                    if (WAIT_STATES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == CntLast) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= bus.req_we;
                addr_q   <= bus.req_addr;
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
            end else if (state_q == StResp && bus.rsp_ready) begin
                rdata_q <= 32'h0;
            end
        end
    end

    // Array is deliberately not reset; rst gating keeps a held-in-reset accept from writing.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && op_we && !fault) begin
            mem[word_idx] <= merged;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= fault;
        end else if (state_q == StResp && bus.rsp_ready) begin
            err_q <= 1'b0;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance a uses two wait states, instance b uses none.
module tb_dmem_responder;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(AW)) bus_a ();
    dmem_responder_if #(.ADDR_W(AW)) bus_b ();

    dmem_responder #(.ADDR_W(AW), .WAIT_STATES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    dmem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    logic          valid_a = 1'b0;
    logic          valid_b = 1'b0;
    logic          drv_we = 1'b0;
    logic          rsp_rdy = 1'b1;
    logic [AW-1:0] drv_addr = '0;
    logic [2:0]    drv_f3 = 3'b000;
    logic [31:0]   drv_wdata = 32'h0;

    assign bus_a.req_valid  = valid_a;
    assign bus_a.req_we     = drv_we;
    assign bus_a.req_addr   = drv_addr;
    assign bus_a.req_funct3 = drv_f3;
    assign bus_a.req_wdata  = drv_wdata;
    assign bus_a.rsp_ready  = rsp_rdy;
    assign bus_b.req_valid  = valid_b;
    assign bus_b.req_we     = drv_we;
    assign bus_b.req_addr   = drv_addr;
    assign bus_b.req_funct3 = drv_f3;
    assign bus_b.req_wdata  = drv_wdata;
    assign bus_b.rsp_ready  = rsp_rdy;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   checks = 0;
    int   errors = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy_of(input bit sel);
        return sel ? bus_b.req_ready : bus_a.req_ready;
    endfunction

    function automatic logic vld_of(input bit sel);
        return sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    endfunction

    always @(negedge clk) begin
        if (rst && bus_a.rsp_valid && bus_a.rsp_ready) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rsp: got rdata %h expected no response", bus_a.rsp_rdata);
            end else begin
                e_a = q_a.pop_front();
                chk("a_rdata", bus_a.rsp_rdata, e_a.rdata);
                chk("a_err", 32'(bus_a.rsp_err), 32'(e_a.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus_b.rsp_valid && bus_b.rsp_ready) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rsp: got rdata %h expected no response", bus_b.rsp_rdata);
            end else begin
                e_b = q_b.pop_front();
                chk("b_rdata", bus_b.rsp_rdata, e_b.rdata);
                chk("b_err", 32'(bus_b.rsp_err), 32'(e_b.err));
            end
        end
    end

    task automatic do_req(input bit sel, input logic we, input logic [AW-1:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n;
        bit got;
        int ws = sel ? 0 : 2;
        @(posedge clk);
        #1;
        drv_we    = we;
        drv_addr  = addr;
        drv_f3    = f3;
        drv_wdata = wd;
        rsp_rdy   = (hold == 0);
        if (sel) valid_b = 1'b1;
        else     valid_a = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rdy_of(sel);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 within 20 cycles");
            valid_a = 1'b0;
            valid_b = 1'b0;
            return;
        end
        if (sel) q_b.push_back(exp_t'{rdata: exp_rd, err: exp_err});
        else     q_a.push_back(exp_t'{rdata: exp_rd, err: exp_err});
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = vld_of(sel);
        end
        chk("latency", 32'(n), 32'(ws + 1));
        if (!got) return;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                chk("hold_valid", 32'(vld_of(sel)), 32'd1);
                chk("hold_rdata", rdata_of(sel), exp_rd);
                chk("hold_req_ready", 32'(rdy_of(sel)), 32'd0);
            end
            @(posedge clk);
            #1;
            rsp_rdy = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("idle_req_ready", 32'(rdy_of(sel)), 32'd1);
            chk("idle_rsp_valid", 32'(vld_of(sel)), 32'd0);
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus_a.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
        chk("rst_b_req_ready", 32'(bus_b.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // T1: store then load, three-cycle latency each
        do_req(0, 1'b1, 8'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 8'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // T2: byte/half lanes; word becomes DEAD55EF then 800155EF
        do_req(0, 1'b1, 8'h11, 3'b000, 32'hFFFFFF55, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 8'h11, 3'b100, 32'h0, 32'h00000055, 1'b0, 0);
        do_req(0, 1'b0, 8'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
        do_req(0, 1'b0, 8'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
        do_req(0, 1'b0, 8'h10, 3'b101, 32'h0, 32'h000055EF, 1'b0, 0);
        do_req(0, 1'b0, 8'h10, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0, 0);
        do_req(0, 1'b0, 8'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0, 0);
        do_req(0, 1'b1, 8'h12, 3'b001, 32'hABCD8001, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 8'h10, 3'b010, 32'h0, 32'h800155EF, 1'b0, 0);

        // T3: response held for five cycles
        do_req(0, 1'b0, 8'h10, 3'b010, 32'h0, 32'h800155EF, 1'b0, 5);

        // T5: misaligned word store, misaligned half load, illegal funct3
        do_req(0, 1'b1, 8'h20, 3'b010, 32'h0BADF00D, 32'h0, 1'b0, 0);
        do_req(0, 1'b1, 8'h22, 3'b010, 32'h12345678, 32'h0, Trap, 0);
        do_req(0, 1'b0, 8'h20, 3'b010, 32'h0, Trap ? 32'h0BADF00D : 32'h12345678, 1'b0, 0);
        do_req(0, 1'b0, 8'h11, 3'b001, 32'h0, Trap ? 32'h0 : 32'h000055EF, Trap, 0);
        do_req(0, 1'b0, 8'h10, 3'b011, 32'h0, Trap ? 32'h0 : 32'h800155EF, Trap, 0);

        // T4: zero wait states, req_valid held high across back-to-back loads
        do_req(1, 1'b1, 8'h10, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        drv_we   = 1'b0;
        drv_addr = 8'h10;
        drv_f3   = 3'b010;
        rsp_rdy  = 1'b1;
        valid_b  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b_req_ready", 32'(bus_b.req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (bus_b.req_ready) q_b.push_back(exp_t'{rdata: 32'hCAFEF00D, err: 1'b0});
        end
        @(posedge clk);
        #1;
        valid_b = 1'b0;

        // T6: reset during WAIT drops the store; earlier contents persist
        do_req(0, 1'b1, 8'h30, 3'b010, 32'h11223344, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        drv_we    = 1'b1;
        drv_addr  = 8'h30;
        drv_f3    = 3'b010;
        drv_wdata = 32'hA5A5A5A5;
        valid_a   = 1'b1;
        @(negedge clk);
        chk("t6_accept", 32'(bus_a.req_ready), 32'd1);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(negedge clk);
        chk("t6_in_wait", 32'(bus_a.req_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_req_ready", 32'(bus_a.req_ready), 32'd1);
        chk("t6_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("t6_rsp_rdata", bus_a.rsp_rdata, 32'h0);
        chk("t6_rsp_err", 32'(bus_a.rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_req(0, 1'b0, 8'h30, 3'b010, 32'h0, 32'h11223344, 1'b0, 0);
        do_req(0, 1'b0, 8'h31, 3'b100, 32'h0, 32'h00000033, 1'b0, 0);
        do_req(1, 1'b0, 8'h10, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        repeat (4) @(negedge clk);
        chk("a_queue_empty", 32'(q_a.size()), 32'd0);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
